// File: rtl/sdram_arb_pkg.sv
// Shared constants and width helpers for the SDRAM request arbiter.
package sdram_arb_pkg;

   localparam int unsigned REQ_VGA   = 0;
   localparam int unsigned REQ_AUDIO = 1;
   localparam int unsigned REQ_DMA   = 2;

   localparam int unsigned DEF_MAX_PEND = 4;

   // Width of a requester index; a single requester still needs one bit.
   function automatic int unsigned id_w(input int unsigned num_req);
      return (num_req < 2) ? 1 : $clog2(num_req);
   endfunction

   function automatic int unsigned pend_w(input int unsigned max_pend);
      return $clog2(max_pend) + 1;
   endfunction

   localparam int unsigned PEND_CNT_W = pend_w(DEF_MAX_PEND);

endpackage

// File: rtl/arb_id_fifo.sv
// Ordered queue of requester IDs for reads already accepted by the SDRAM slave.
module arb_id_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_c,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             empty_q, empty_d;
   logic             do_push, do_pop;
   logic [WIDTH-1:0] mem_q [DEPTH];

   // A push into a full queue is only honoured when a pop frees a slot.
   always_comb begin
      do_pop   = pop && !empty_q;
      do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
      wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
      rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
      count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      empty_d  = (count_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         empty_q  <= empty_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

   assign head_c = mem_q[rd_ptr_q];
   assign count  = count_q;
   assign empty  = empty_q;

endmodule

// File: rtl/sdram_req_arbiter.sv
// Round-robin arbiter sharing one SDRAM Avalon-MM port, with in-order read return routing.
// Optional build macro SDRAM_ARB_VGA_PRIO_EN gives requester 0 (VGA) absolute priority.
module sdram_req_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ  = 3,
   parameter int unsigned ADDR_W   = 25,
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned MAX_PEND = 4
) (
   input  logic                        clk_clk,
   input  logic                        reset_reset_n,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ-1:0]          req_we,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic [NUM_REQ-1:0]          rsp_valid,
   output logic [DATA_W-1:0]           rsp_data,
   output logic [ADDR_W-1:0]           m_address,
   output logic                        m_read,
   output logic                        m_write,
   output logic [DATA_W-1:0]           m_writedata,
   input  logic                        m_waitrequest,
   input  logic [DATA_W-1:0]           m_readdata,
   input  logic                        m_readdatavalid,
   output logic [$clog2(MAX_PEND):0]   pend_count,
   output logic                        err_orphan
);

   localparam int unsigned ID_W   = id_w(NUM_REQ);
   localparam int unsigned PEND_W = pend_w(MAX_PEND);
   localparam int unsigned SUM_W  = PEND_W + 1;

   logic              cmd_rd_q, cmd_rd_d;
   logic              cmd_wr_q, cmd_wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [ID_W-1:0]   cmd_id_q, cmd_id_d;
   logic [ID_W-1:0]   last_grant_q, last_grant_d;
   logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic              err_orphan_q, err_orphan_d;

   logic              slot_free, push, pop, room;
   logic [NUM_REQ-1:0] elig;
   logic              found, vga_win, sel_we;
   logic [ID_W-1:0]   winner, cand;
   int unsigned       idx;
   logic [PEND_W-1:0] fifo_count;
   logic [ID_W-1:0]   fifo_head;
   logic              fifo_empty;

   // A read in flight this cycle counts against the limit before it is pushed.
   always_comb begin
      slot_free = !(cmd_rd_q || cmd_wr_q) || !m_waitrequest;
      push      = cmd_rd_q && !m_waitrequest;
      pop       = m_readdatavalid && !fifo_empty;
      room      = (SUM_W'(fifo_count) + SUM_W'(push)) < SUM_W'(MAX_PEND);
      elig      = req_valid & (req_we | {NUM_REQ{room}});
   end

   // Scan starting after the last grant, wrapping modulo NUM_REQ.
   always_comb begin
      found   = 1'b0;
      vga_win = 1'b0;
      winner  = last_grant_q;
      idx     = 0;
      cand    = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         idx  = (32'(last_grant_q) + k) % NUM_REQ;
         cand = ID_W'(idx);
`ifdef SDRAM_ARB_VGA_PRIO_EN
         if (!found && elig[cand] && (idx != REQ_VGA)) begin
`else
         if (!found && elig[cand]) begin
`endif
            found  = 1'b1;
            winner = cand;
         end
      end
`ifdef SDRAM_ARB_VGA_PRIO_EN
      if (elig[ID_W'(REQ_VGA)]) begin
         found   = 1'b1;
         vga_win = 1'b1;
         winner  = ID_W'(REQ_VGA);
      end
`endif
      sel_we    = req_we[winner];
      req_ready = '0;
      if (slot_free && found) req_ready[winner] = 1'b1;
   end

   always_comb begin
      cmd_rd_d     = cmd_rd_q;
      cmd_wr_d     = cmd_wr_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      cmd_id_d     = cmd_id_q;
      last_grant_d = last_grant_q;
      rsp_valid_d  = '0;
      rsp_data_d   = rsp_data_q;
      err_orphan_d = err_orphan_q || (m_readdatavalid && fifo_empty);
      if (slot_free) begin
         cmd_rd_d = found && !sel_we;
         cmd_wr_d = found && sel_we;
         if (found) begin
            addr_d   = req_addr[32'(winner)*ADDR_W +: ADDR_W];
            wdata_d  = req_wdata[32'(winner)*DATA_W +: DATA_W];
            cmd_id_d = winner;
            if (!vga_win) last_grant_d = winner;
         end
      end
      if (pop) begin
         rsp_valid_d[fifo_head] = 1'b1;
         rsp_data_d             = m_readdata;
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         cmd_rd_q     <= 1'b0;
         cmd_wr_q     <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         cmd_id_q     <= '0;
         last_grant_q <= ID_W'(NUM_REQ - 1);
         rsp_valid_q  <= '0;
         rsp_data_q   <= '0;
         err_orphan_q <= 1'b0;
      end else begin
         cmd_rd_q     <= cmd_rd_d;
         cmd_wr_q     <= cmd_wr_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         cmd_id_q     <= cmd_id_d;
         last_grant_q <= last_grant_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_data_q   <= rsp_data_d;
         err_orphan_q <= err_orphan_d;
      end
   end

   arb_id_fifo #(
      .DEPTH (MAX_PEND),
      .WIDTH (ID_W)
   ) u_id_fifo (
      .clk       (clk_clk),
      .rst_n     (reset_reset_n),
      .push      (push),
      .push_data (cmd_id_q),
      .pop       (pop),
      .head_c    (fifo_head),
      .count     (fifo_count),
      .empty     (fifo_empty)
   );

   assign m_read      = cmd_rd_q;
   assign m_write     = cmd_wr_q;
   assign m_address   = addr_q;
   assign m_writedata = wdata_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_data    = rsp_data_q;
   assign pend_count  = fifo_count;
   assign err_orphan  = err_orphan_q;

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Directed bench for sdram_req_arbiter: vector table plus hand-written corner sequences.
module tb_sdram_req_arbiter;

   localparam int unsigned NUM_REQ  = 3;
   localparam int unsigned ADDR_W   = 25;
   localparam int unsigned DATA_W   = 16;
   localparam int unsigned MAX_PEND = 4;
   localparam int unsigned NVEC     = 14;

   logic                      clk_clk = 1'b0;
   logic                      reset_reset_n = 1'b0;
   logic [NUM_REQ-1:0]        req_valid = '0;
   logic [NUM_REQ-1:0]        req_we = '0;
   logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
   logic [NUM_REQ*DATA_W-1:0] req_wdata = '0;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [DATA_W-1:0]         rsp_data;
   logic [ADDR_W-1:0]         m_address;
   logic                      m_read;
   logic                      m_write;
   logic [DATA_W-1:0]         m_writedata;
   logic                      m_waitrequest = 1'b0;
   logic [DATA_W-1:0]         m_readdata = '0;
   logic                      m_readdatavalid = 1'b0;
   logic [2:0]                pend_count;
   logic                      err_orphan;

   sdram_req_arbiter #(
      .NUM_REQ (NUM_REQ), .ADDR_W (ADDR_W), .DATA_W (DATA_W), .MAX_PEND (MAX_PEND)
   ) dut (
      .clk_clk         (clk_clk),
      .reset_reset_n   (reset_reset_n),
      .req_valid       (req_valid),
      .req_we          (req_we),
      .req_addr        (req_addr),
      .req_wdata       (req_wdata),
      .req_ready       (req_ready),
      .rsp_valid       (rsp_valid),
      .rsp_data        (rsp_data),
      .m_address       (m_address),
      .m_read          (m_read),
      .m_write         (m_write),
      .m_writedata     (m_writedata),
      .m_waitrequest   (m_waitrequest),
      .m_readdata      (m_readdata),
      .m_readdatavalid (m_readdatavalid),
      .pend_count      (pend_count),
      .err_orphan      (err_orphan)
   );

   always #5 clk_clk = ~clk_clk;

   typedef struct {
      logic [2:0]  valid;
      logic        rdv;
      logic [15:0] rdata;
      logic [2:0]  e_ready;
      logic        e_rd;
      logic [24:0] e_addr;
      logic [2:0]  e_pend;
      logic [2:0]  e_rsp;
      logic [15:0] e_rdata;
   } vec_t;

   vec_t tbl [NVEC];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   pulses  = 0;
   logic [2:0] exp_d [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs just after the falling edge, then let them settle.
   task automatic step_in(input logic [2:0] v, input logic [2:0] we, input logic w,
                          input logic rdv, input logic [15:0] rd);
      @(negedge clk_clk);
      req_valid = v; req_we = we; m_waitrequest = w;
      m_readdatavalid = rdv; m_readdata = rd;
      #1;
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk_clk);
      reset_reset_n = 1'b0;
      req_valid = '0; req_we = '0; m_waitrequest = 1'b0;
      m_readdatavalid = 1'b0; m_readdata = '0;
      #1;
      chk({tag, " rst err_orphan"}, 32'(err_orphan), 32'd0);
      chk({tag, " rst m_read|m_write"}, 32'({m_read, m_write}), 32'd0);
      chk({tag, " rst pend_count"}, 32'(pend_count), 32'd0);
      chk({tag, " rst rsp_valid"}, 32'(rsp_valid), 32'd0);
      @(negedge clk_clk);
      reset_reset_n = 1'b1;
   endtask

   initial begin
      req_addr  = {25'h0001020, 25'h0001010, 25'h0001000};
      req_wdata = {16'hA002, 16'hA001, 16'hA000};

      //          valid   rdv   rdata     ready   rd    addr          pend  rsp     rsp_data
      tbl[0]  = '{3'b111, 1'b0, 16'h0000, 3'b001, 1'b0, 25'h0000000, 3'd0, 3'b000, 16'h0000};
      tbl[1]  = '{3'b111, 1'b0, 16'h0000, 3'b010, 1'b1, 25'h0001000, 3'd0, 3'b000, 16'h0000};
      tbl[2]  = '{3'b111, 1'b0, 16'h0000, 3'b100, 1'b1, 25'h0001010, 3'd1, 3'b000, 16'h0000};
      tbl[3]  = '{3'b111, 1'b0, 16'h0000, 3'b001, 1'b1, 25'h0001020, 3'd2, 3'b000, 16'h0000};
      tbl[4]  = '{3'b111, 1'b1, 16'h1000, 3'b000, 1'b1, 25'h0001000, 3'd3, 3'b000, 16'h0000};
      tbl[5]  = '{3'b111, 1'b1, 16'h1010, 3'b010, 1'b0, 25'h0001000, 3'd3, 3'b001, 16'h1000};
      tbl[6]  = '{3'b111, 1'b1, 16'h1020, 3'b100, 1'b1, 25'h0001010, 3'd2, 3'b010, 16'h1010};
      tbl[7]  = '{3'b111, 1'b1, 16'h1000, 3'b001, 1'b1, 25'h0001020, 3'd2, 3'b100, 16'h1020};
      tbl[8]  = '{3'b111, 1'b0, 16'h0000, 3'b010, 1'b1, 25'h0001000, 3'd2, 3'b001, 16'h1000};
      tbl[9]  = '{3'b000, 1'b1, 16'h1010, 3'b000, 1'b1, 25'h0001010, 3'd3, 3'b000, 16'h1000};
      tbl[10] = '{3'b000, 1'b1, 16'h1020, 3'b000, 1'b0, 25'h0001010, 3'd3, 3'b010, 16'h1010};
      tbl[11] = '{3'b000, 1'b1, 16'h1000, 3'b000, 1'b0, 25'h0001010, 3'd2, 3'b100, 16'h1020};
      tbl[12] = '{3'b000, 1'b1, 16'h1010, 3'b000, 1'b0, 25'h0001010, 3'd1, 3'b001, 16'h1000};
      tbl[13] = '{3'b000, 1'b0, 16'h0000, 3'b000, 1'b0, 25'h0001010, 3'd0, 3'b010, 16'h1010};

      do_reset("A");
      // Continuous round-robin reads with responses three cycles after acceptance.
      for (int i = 0; i < int'(NVEC); i++) begin
         step_in(tbl[i].valid, 3'b000, 1'b0, tbl[i].rdv, tbl[i].rdata);
         chk($sformatf("A%0d req_ready", i), 32'(req_ready), 32'(tbl[i].e_ready));
         chk($sformatf("A%0d m_read", i), 32'(m_read), 32'(tbl[i].e_rd));
         chk($sformatf("A%0d m_write", i), 32'(m_write), 32'd0);
         chk($sformatf("A%0d m_address", i), 32'(m_address), 32'(tbl[i].e_addr));
         chk($sformatf("A%0d pend_count", i), 32'(pend_count), 32'(tbl[i].e_pend));
         chk($sformatf("A%0d rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].e_rsp));
         chk($sformatf("A%0d rsp_data", i), 32'(rsp_data), 32'(tbl[i].e_rdata));
      end

      // Write held stable across five waitrequest cycles.
      do_reset("B");
      req_addr[ADDR_W +: ADDR_W]  = 25'h0000100;
      req_wdata[DATA_W +: DATA_W] = 16'hBEEF;
      step_in(3'b010, 3'b010, 1'b1, 1'b0, 16'h0);
      chk("B0 req_ready", 32'(req_ready), 32'b010);
      pulses = 32'(req_ready[1]);
      for (int i = 1; i <= 6; i++) begin
         step_in((i == 6) ? 3'b000 : 3'b010, 3'b010, (i == 6) ? 1'b0 : 1'b1, 1'b0, 16'h0);
         pulses += 32'(req_ready[1]);
         chk($sformatf("B%0d req_ready", i), 32'(req_ready), 32'd0);
         chk($sformatf("B%0d m_write", i), 32'(m_write), 32'd1);
         chk($sformatf("B%0d m_read", i), 32'(m_read), 32'd0);
         chk($sformatf("B%0d m_address", i), 32'(m_address), 32'h100);
         chk($sformatf("B%0d m_writedata", i), 32'(m_writedata), 32'hBEEF);
      end
      step_in(3'b000, 3'b000, 1'b0, 1'b0, 16'h0);
      chk("B7 m_write", 32'(m_write), 32'd0);
      chk("B ready pulses", 32'(pulses), 32'd1);

      // Pending limit: reads stall at MAX_PEND while a write still gets through.
      do_reset("C");
      for (int i = 0; i < 4; i++) begin
         step_in(3'b100, 3'b000, 1'b0, 1'b0, 16'h0);
         chk($sformatf("C%0d req_ready", i), 32'(req_ready), 32'b100);
         chk($sformatf("C%0d pend_count", i), 32'(pend_count), (i == 0) ? 32'd0 : 32'(i - 1));
      end
      step_in(3'b110, 3'b010, 1'b0, 1'b0, 16'h0);
      chk("C4 req_ready", 32'(req_ready), 32'b010);
      chk("C4 pend_count", 32'(pend_count), 32'd3);
      step_in(3'b100, 3'b000, 1'b0, 1'b0, 16'h0);
      chk("C5 req_ready", 32'(req_ready), 32'd0);
      chk("C5 pend_count", 32'(pend_count), 32'd4);
      chk("C5 m_write", 32'(m_write), 32'd1);
      chk("C5 m_address", 32'(m_address), 32'h100);
      step_in(3'b100, 3'b000, 1'b0, 1'b0, 16'h0);
      chk("C6 req_ready", 32'(req_ready), 32'd0);
      chk("C6 pend_count", 32'(pend_count), 32'd4);
      step_in(3'b100, 3'b000, 1'b0, 1'b1, 16'h5555);
      chk("C7 req_ready", 32'(req_ready), 32'd0);
      step_in(3'b100, 3'b000, 1'b0, 1'b0, 16'h0);
      chk("C8 req_ready", 32'(req_ready), 32'b100);
      chk("C8 pend_count", 32'(pend_count), 32'd3);
      chk("C8 rsp_valid", 32'(rsp_valid), 32'b100);
      chk("C8 rsp_data", 32'(rsp_data), 32'h5555);
      step_in(3'b000, 3'b000, 1'b0, 1'b0, 16'h0);
      chk("C9 m_read", 32'(m_read), 32'd1);
      chk("C9 m_address", 32'(m_address), 32'h1020);

      // Orphan response sets a sticky flag that only reset clears.
      do_reset("D");
      step_in(3'b000, 3'b000, 1'b0, 1'b1, 16'h1234);
      chk("D0 err_orphan", 32'(err_orphan), 32'd0);
      for (int i = 1; i <= 3; i++) begin
         step_in(3'b000, 3'b000, 1'b0, 1'b0, 16'h0);
         chk($sformatf("D%0d err_orphan", i), 32'(err_orphan), 32'd1);
         chk($sformatf("D%0d rsp_valid", i), 32'(rsp_valid), 32'd0);
         chk($sformatf("D%0d pend_count", i), 32'(pend_count), 32'd0);
      end

      // Grant pattern with requesters 0 and 1, then 1 and 2, all writing.
`ifdef SDRAM_ARB_VGA_PRIO_EN
      exp_d = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b100, 3'b010};
`else
      exp_d = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b100, 3'b010, 3'b100};
`endif
      do_reset("E");
      for (int i = 0; i < 7; i++) begin
         step_in((i < 4) ? 3'b011 : 3'b110, 3'b111, 1'b0, 1'b0, 16'h0);
         chk($sformatf("E%0d req_ready", i), 32'(req_ready), 32'(exp_d[i]));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
